// File: rtl/posit_decode_arbiter.sv
// Round-robin shared posit decoder: NREQ requesters feed one decode datapath,
// and the result lands in a one-entry output buffer tagged with the winner's index.
module posit_decode_arbiter #(
    parameter int N    = 16,
    parameter int ES   = 1,
    parameter int NREQ = 3,
    localparam int ID_W      = $clog2(NREQ),
    localparam int TE_SIZE   = ES + $clog2(N) + 1,
    localparam int MANT_SIZE = N - 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*N-1:0]      req_bits,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_sign,
    output logic [TE_SIZE-1:0]     out_te,
    output logic [MANT_SIZE-1:0]   out_mant,
    output logic                   out_zero,
    output logic                   out_nar
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     w_win;
    logic                w_found;
    logic                w_can;
    logic                w_grant;

    logic [N-1:0]        w_x;
    logic [N-1:0]        w_abs;
    logic [N-2:0]        w_rem;
    logic [CW-1:0]       w_run;
    logic                w_stop;
    logic [N-2:0]        w_shift;
    logic [N-2:0]        w_fshift;
    logic [TE_SIZE-1:0]  w_k;
    logic [TE_SIZE-1:0]  w_exp;
    logic                w_zero;
    logic                w_nar;
    logic                w_sign;
    logic [TE_SIZE-1:0]  w_te;
    logic [MANT_SIZE-1:0] w_mant;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return ID_W'(s);
    endfunction

    // Walk offsets from far to near so the closest valid index to r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[wrap_add(r_ptr, i)]) begin
                w_found = 1'b1;
                w_win   = wrap_add(r_ptr, i);
            end
        end
    end

    assign w_can     = (r_state == S_EMPTY) || out_ready;
    assign w_grant   = w_found && w_can && !rst;
    assign req_ready = w_grant ? (NREQ'(1) << w_win) : '0;
    assign out_valid = (r_state == S_FULL);

    always_comb begin
        w_x    = req_bits[int'(w_win)*N +: N];
        w_zero = (w_x == '0);
        w_nar  = (w_x == {1'b1, {(N-1){1'b0}}});
        w_abs  = w_x[N-1] ? -w_x : w_x;
        w_rem  = (N-1)'(w_abs);
        w_run  = '0;
        w_stop = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!w_stop && (w_rem[i] == w_rem[N-2])) w_run = w_run + CW'(1);
            else                                      w_stop = 1'b1;
        end
        // Drop the regime run and its terminator; exponent then fraction follow.
        w_shift  = w_rem << (w_run + CW'(1));
        w_exp    = TE_SIZE'(w_shift >> (N - 1 - ES));
        w_fshift = w_shift << ES;
        w_k      = w_rem[N-2] ? (TE_SIZE'(w_run) - TE_SIZE'(1))
                              : (TE_SIZE'(0) - TE_SIZE'(w_run));
        w_sign   = w_x[N-1];
        w_te     = (w_k << ES) | w_exp;
        w_mant   = {1'b1, (N-3)'(w_fshift >> 2)};
        if (w_zero || w_nar) begin
            w_sign = w_nar;
            w_te   = '0;
            w_mant = '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: if (w_grant) w_state_nxt = S_FULL;
            S_FULL: begin
                if (w_grant)        w_state_nxt = S_FULL;
                else if (out_ready) w_state_nxt = S_EMPTY;
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_EMPTY;
            r_ptr    <= '0;
            out_id   <= '0;
            out_sign <= 1'b0;
            out_te   <= '0;
            out_mant <= '0;
            out_zero <= 1'b0;
            out_nar  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_ptr    <= wrap_add(w_win, 1);
                out_id   <= w_win;
                out_sign <= w_sign;
                out_te   <= w_te;
                out_mant <= w_mant;
                out_zero <= w_zero;
                out_nar  <= w_nar;
            end
        end
    end

endmodule

// File: tb/tb_posit_decode_arbiter.sv
// Randomized bench for posit_decode_arbiter: a bit-serial posit reference and a
// round-robin/buffer model predict every req_ready and output each cycle.
module tb_posit_decode_arbiter;
    localparam int NA = 8;
    localparam int ESA = 0;
    localparam int RA = 3;
    localparam int IDA = 2;
    localparam int TEA = 4;
    localparam int MA = 6;
    localparam int NB = 16;
    localparam int ESB = 1;
    localparam int RB = 2;
    localparam int IDB = 1;
    localparam int TEB = 6;
    localparam int MB = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [RA-1:0]    a_valid, a_ready;
    logic [RA*NA-1:0] a_bits;
    logic             a_ovalid, a_ordy, a_sign, a_zero, a_nar;
    logic [IDA-1:0]   a_id;
    logic [TEA-1:0]   a_te;
    logic [MA-1:0]    a_mant;

    logic [RB-1:0]    b_valid, b_ready;
    logic [RB*NB-1:0] b_bits;
    logic             b_ovalid, b_ordy, b_sign, b_zero, b_nar;
    logic [IDB-1:0]   b_id;
    logic [TEB-1:0]   b_te;
    logic [MB-1:0]    b_mant;

    posit_decode_arbiter #(.N(NA), .ES(ESA), .NREQ(RA)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_ready(a_ready), .req_bits(a_bits),
        .out_valid(a_ovalid), .out_ready(a_ordy), .out_id(a_id),
        .out_sign(a_sign), .out_te(a_te), .out_mant(a_mant),
        .out_zero(a_zero), .out_nar(a_nar)
    );

    posit_decode_arbiter #(.N(NB), .ES(ESB), .NREQ(RB)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_ready), .req_bits(b_bits),
        .out_valid(b_ovalid), .out_ready(b_ordy), .out_id(b_id),
        .out_sign(b_sign), .out_te(b_te), .out_mant(b_mant),
        .out_zero(b_zero), .out_nar(b_nar)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic              m_full, m_sign, m_zero, m_nar;
    int                m_ptr, m_id, m_te;
    longint unsigned   m_mant;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] tmask(input int v, input int w);
        logic [63:0] x;
        x = 64'(longint'(v));
        return x & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic bit_at(input longint unsigned x, input int p);
        return (p >= 0) ? x[p] : 1'b0;
    endfunction

    // Reads the posit MSB-first as the number format defines it.
    function automatic void posit_ref(input int n, input int es,
                                      input longint unsigned x,
                                      output logic s, output int te,
                                      output longint unsigned mant,
                                      output logic z, output logic nar);
        longint unsigned msk, v;
        int pos, m, k, e;
        logic r0;
        msk = (64'd1 << n) - 64'd1;
        v = x & msk;
        s = 1'b0; te = 0; mant = 0; z = 1'b0; nar = 1'b0;
        if (v == 0) begin
            z = 1'b1;
            return;
        end
        if (v == (64'd1 << (n - 1))) begin
            nar = 1'b1;
            s = 1'b1;
            return;
        end
        s = v[n-1];
        if (s) v = (~v + 64'd1) & msk;
        pos = n - 2;
        r0 = v[pos];
        m = 0;
        while (pos >= 0 && bit_at(v, pos) == r0) begin
            m++;
            pos--;
        end
        k = r0 ? m - 1 : -m;
        pos--;
        e = 0;
        for (int i = 0; i < es; i++) begin
            e = e * 2 + int'(bit_at(v, pos));
            pos--;
        end
        mant = 1;
        for (int i = 0; i < n - 3; i++) begin
            mant = mant * 2 + longint'(bit_at(v, pos));
            pos--;
        end
        te = k * (1 << es) + e;
    endfunction

    function automatic logic [31:0] rnd_op(input int n);
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0: r = 32'd0;
            1: r = 32'd1 << (n - 1);
            2: r = 32'd1;
            3: r = (32'd1 << (n - 1)) - 32'd1;
            4: r = '1;
            default: r = $urandom;
        endcase
        return r & ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [RA*NA-1:0] rnd_a();
        logic [RA*NA-1:0] r;
        for (int i = 0; i < RA; i++) r[i*NA +: NA] = NA'(rnd_op(NA));
        return r;
    endfunction

    function automatic void a_arb(output logic found, output int win);
        found = 1'b0;
        win = 0;
        for (int i = 0; i < RA; i++) begin
            int j;
            j = (m_ptr + i) % RA;
            if (a_valid[j]) begin
                found = 1'b1;
                win = j;
                break;
            end
        end
    endfunction

    task automatic a_check();
        chk("a_out_valid", 64'(a_ovalid), 64'(m_full));
        chk("a_out_id",    64'(a_id),     tmask(m_id, IDA));
        chk("a_out_sign",  64'(a_sign),   64'(m_sign));
        chk("a_out_te",    64'(a_te),     tmask(m_te, TEA));
        chk("a_out_mant",  64'(a_mant),   m_mant);
        chk("a_out_zero",  64'(a_zero),   64'(m_zero));
        chk("a_out_nar",   64'(a_nar),    64'(m_nar));
    endtask

    task automatic m_reset();
        m_full = 1'b0; m_sign = 1'b0; m_zero = 1'b0; m_nar = 1'b0;
        m_ptr = 0; m_id = 0; m_te = 0; m_mant = 0;
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic a_cyc(input logic [RA-1:0] v, input logic [RA*NA-1:0] b,
                         input logic r);
        logic f;
        int w;
        logic [RA-1:0] er;
        a_valid = v;
        a_bits = b;
        a_ordy = r;
        @(negedge clk);
        a_arb(f, w);
        er = '0;
        if (f && (!m_full || r)) er[w] = 1'b1;
        chk("a_req_ready", 64'(a_ready), 64'(er));
        @(posedge clk);
        if (f && (!m_full || r)) begin
            m_full = 1'b1;
            m_id = w;
            posit_ref(NA, ESA, 64'(b[w*NA +: NA]), m_sign, m_te, m_mant,
                      m_zero, m_nar);
            m_ptr = (w + 1) % RA;
        end else if (m_full && r) begin
            m_full = 1'b0;
        end
        #1 a_check();
    endtask

    task automatic dir(input logic [7:0] val, input logic s, input int te,
                       input int mant, input logic z, input logic n);
        a_cyc(3'b001, {16'h0, val}, 1'b1);
        chk("dir_sign", 64'(a_sign), 64'(s));
        chk("dir_te",   64'(a_te),   tmask(te, TEA));
        chk("dir_mant", 64'(a_mant), tmask(mant, MA));
        chk("dir_zero", 64'(a_zero), 64'(z));
        chk("dir_nar",  64'(a_nar),  64'(n));
    endtask

    initial begin
        logic bs, bz, bn;
        int bte, b_ptr, bw;
        longint unsigned bmant;

        m_reset();
        b_ptr = 0;
        a_valid = '1; a_bits = '0; a_ordy = 1'b1;
        b_valid = '0; b_bits = '0; b_ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_req_ready", 64'(a_ready), 64'd0);
        a_check();
        chk("rst_b_out_valid", 64'(b_ovalid), 64'd0);
        a_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        dir(8'h40, 1'b0,  0, 'h20, 1'b0, 1'b0);
        dir(8'h60, 1'b0,  1, 'h20, 1'b0, 1'b0);
        dir(8'h50, 1'b0,  0, 'h30, 1'b0, 1'b0);
        dir(8'hC0, 1'b1,  0, 'h20, 1'b0, 1'b0);
        dir(8'h00, 1'b0,  0, 'h00, 1'b1, 1'b0);
        dir(8'h80, 1'b1,  0, 'h00, 1'b0, 1'b1);
        dir(8'h7F, 1'b0,  6, 'h20, 1'b0, 1'b0);
        dir(8'h01, 1'b0, -6, 'h20, 1'b0, 1'b0);
        a_cyc(3'b000, '0, 1'b1);

        repeat (6) a_cyc(3'b111, rnd_a(), 1'b1);

        a_cyc(3'b111, rnd_a(), 1'b1);
        repeat (3) a_cyc(3'b111, rnd_a(), 1'b0);
        a_cyc(3'b010, rnd_a(), 1'b1);
        chk("bp_valid", 64'(a_ovalid), 64'd1);
        chk("bp_id", 64'(a_id), 64'd1);

        a_cyc(3'b010, rnd_a(), 1'b1);
        chk("skip_id", 64'(a_id), 64'd1);
        a_cyc(3'b100, rnd_a(), 1'b1);
        chk("wrap_id2", 64'(a_id), 64'd2);
        a_cyc(3'b111, rnd_a(), 1'b1);
        chk("wrap_id0", 64'(a_id), 64'd0);

        a_valid = 3'b111;
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(a_ovalid), 64'd0);
        chk("arst_req_ready", 64'(a_ready), 64'd0);
        m_reset();
        b_ptr = 0;
        a_check();
        a_valid = '0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 a_check();
        a_cyc(3'b111, rnd_a(), 1'b1);
        chk("post_rst_id", 64'(a_id), 64'd0);

        repeat (300)
            a_cyc(RA'($urandom_range(0, 7)), rnd_a(),
                  $urandom_range(0, 3) != 0);
        a_valid = '0;

        b_valid = '1;
        b_ordy = 1'b1;
        repeat (150) begin
            for (int i = 0; i < RB; i++) b_bits[i*NB +: NB] = NB'(rnd_op(NB));
            @(negedge clk);
            chk("b_req_ready", 64'(b_ready), 64'd1 << b_ptr);
            @(posedge clk);
            bw = b_ptr;
            posit_ref(NB, ESB, 64'(b_bits[bw*NB +: NB]), bs, bte, bmant, bz, bn);
            b_ptr = (b_ptr + 1) % RB;
            #1;
            chk("b_out_valid", 64'(b_ovalid), 64'd1);
            chk("b_out_id",    64'(b_id),     tmask(bw, IDB));
            chk("b_out_sign",  64'(b_sign),   64'(bs));
            chk("b_out_te",    64'(b_te),     tmask(bte, TEB));
            chk("b_out_mant",  64'(b_mant),   bmant);
            chk("b_out_zero",  64'(b_zero),   64'(bz));
            chk("b_out_nar",   64'(b_nar),    64'(bn));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
